// File: rtl/ldr_word_bridge.sv
// Byte-to-word bridge between the HPS ioctl download stream and a 16-bit core memory port.
// Packs big-endian words through a pending/skid stage into a small FIFO drained by a level-request/ack handshake.
module ldr_word_bridge #(
    parameter logic [7:0]  INDEX = 8'd0,
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        ldr_aen,
    output logic        ldr_wr,
    output logic [19:0] ldr_addr,
    output logic [15:0] ldr_wdat,
    output logic [1:0]  ldr_be,
    input  logic        ldr_ack,
    output logic        ldr_done,
    output logic        ldr_ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_HIGH = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          dl_q;
    logic          ack_q;
    logic          pend_vld_q, pend_vld_d;
    logic [18:0]   pend_addr_q, pend_addr_d;
    logic [7:0]    pend_dat_q, pend_dat_d;
    logic          skid_vld_q, skid_vld_d;
    logic [18:0]   skid_addr_q, skid_addr_d;
    logic [7:0]    skid_dat_q, skid_dat_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_q, wr_d;
    logic [19:0]   oaddr_q, oaddr_d;
    logic [15:0]   odat_q, odat_d;
    logic [1:0]    obe_q, obe_d;
    logic          ovf_q, ovf_d;
    logic          wait_q, wait_d;

    logic [18:0]   fifo_addr [DEPTH];
    logic [15:0]   fifo_dat  [DEPTH];
    logic [1:0]    fifo_be   [DEPTH];

    logic          push;
    logic [18:0]   push_addr;
    logic [15:0]   push_dat;
    logic [1:0]    push_be;
    logic          pop;
    logic          fifo_can;
    logic          slot_free;
    logic          byte_v;
    logic [18:0]   byte_a;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^ioctl_addr[24:20];

    assign pop       = wr_q & ldr_ack & ~ack_q;
    assign fifo_can  = (count_q != CNT_FULL) | pop;
    assign slot_free = fifo_can & ~skid_vld_q;
    assign byte_v    = (state_q == S_LOAD) & ioctl_download & ioctl_wr & (ioctl_index == INDEX);
    assign byte_a    = ioctl_addr[19:1];

    always_comb begin
        push        = 1'b0;
        push_addr   = '0;
        push_dat    = '0;
        push_be     = '0;
        pend_vld_d  = pend_vld_q;
        pend_addr_d = pend_addr_q;
        pend_dat_d  = pend_dat_q;
        skid_vld_d  = skid_vld_q;
        skid_addr_d = skid_addr_q;
        skid_dat_d  = skid_dat_q;
        ovf_d       = ovf_q;

        // The skid word owns the push slot; any byte needing a push this cycle is lost.
        if (skid_vld_q && fifo_can) begin
            push       = 1'b1;
            push_addr  = skid_addr_q;
            push_dat   = {8'h00, skid_dat_q};
            push_be    = 2'b01;
            skid_vld_d = 1'b0;
        end

        if (byte_v) begin
            if (!ioctl_addr[0]) begin
                if (!pend_vld_q) begin
                    pend_vld_d  = 1'b1;
                    pend_addr_d = byte_a;
                    pend_dat_d  = ioctl_dout;
                end else if (slot_free) begin
                    push        = 1'b1;
                    push_addr   = pend_addr_q;
                    push_dat    = {pend_dat_q, 8'h00};
                    push_be     = 2'b10;
                    pend_addr_d = byte_a;
                    pend_dat_d  = ioctl_dout;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (!slot_free) begin
                ovf_d = 1'b1;
            end else if (pend_vld_q && (pend_addr_q == byte_a)) begin
                push       = 1'b1;
                push_addr  = pend_addr_q;
                push_dat   = {pend_dat_q, ioctl_dout};
                push_be    = 2'b11;
                pend_vld_d = 1'b0;
            end else if (pend_vld_q) begin
                push        = 1'b1;
                push_addr   = pend_addr_q;
                push_dat    = {pend_dat_q, 8'h00};
                push_be     = 2'b10;
                pend_vld_d  = 1'b0;
                skid_vld_d  = 1'b1;
                skid_addr_d = byte_a;
                skid_dat_d  = ioctl_dout;
            end else begin
                push      = 1'b1;
                push_addr = byte_a;
                push_dat  = {8'h00, ioctl_dout};
                push_be   = 2'b01;
            end
        end

        if ((state_q == S_FLUSH) && !skid_vld_q && pend_vld_q && fifo_can) begin
            push       = 1'b1;
            push_addr  = pend_addr_q;
            push_dat   = {pend_dat_q, 8'h00};
            push_be    = 2'b10;
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ioctl_download && !dl_q && (ioctl_index == INDEX)) state_d = S_LOAD;
            S_LOAD:  if (!ioctl_download && dl_q) state_d = S_FLUSH;
            S_FLUSH: if ((count_q == '0) && !pend_vld_q && !skid_vld_q && !wr_q) state_d = S_DONE;
            default: state_d = S_DONE;
        endcase
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PTR_ONE : wptr_q;
        rptr_d  = pop ? rptr_q + PTR_ONE : rptr_q;
        count_d = count_q;
        if (push && !pop) count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;

        // The request drops for at least one cycle after each pop before presenting the next head.
        wr_d    = wr_q;
        oaddr_d = oaddr_q;
        odat_d  = odat_q;
        obe_d   = obe_q;
        if (pop) begin
            wr_d = 1'b0;
        end else if (!wr_q && (count_q != '0)) begin
            wr_d    = 1'b1;
            oaddr_d = {fifo_addr[rptr_q], 1'b0};
            odat_d  = fifo_dat[rptr_q];
            obe_d   = fifo_be[rptr_q];
        end

        wait_d = (count_d >= CNT_HIGH) | skid_vld_d | (state_d == S_FLUSH);
    end

    always_ff @(posedge clk_sys) begin
        dl_q <= ioctl_download;
        if (push) begin
            fifo_addr[wptr_q] <= push_addr;
            fifo_dat[wptr_q]  <= push_dat;
            fifo_be[wptr_q]   <= push_be;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ack_q       <= 1'b0;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            pend_dat_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_addr_q <= '0;
            skid_dat_q  <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            wr_q        <= 1'b0;
            oaddr_q     <= '0;
            odat_q      <= '0;
            obe_q       <= '0;
            ovf_q       <= 1'b0;
            wait_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ldr_ack;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            pend_dat_q  <= pend_dat_d;
            skid_vld_q  <= skid_vld_d;
            skid_addr_q <= skid_addr_d;
            skid_dat_q  <= skid_dat_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            wr_q        <= wr_d;
            oaddr_q     <= oaddr_d;
            odat_q      <= odat_d;
            obe_q       <= obe_d;
            ovf_q       <= ovf_d;
            wait_q      <= wait_d;
        end
    end

    assign ioctl_wait = wait_q;
    assign ldr_aen    = (state_q == S_LOAD) || (state_q == S_FLUSH);
    assign ldr_done   = (state_q == S_DONE);
    assign ldr_wr     = wr_q;
    assign ldr_addr   = oaddr_q;
    assign ldr_wdat   = odat_q;
    assign ldr_be     = obe_q;
    assign ldr_ovf    = ovf_q;

endmodule
